// File: rtl/reg_demux_pkg.sv
// reg_demux_pkg: FSM state type and index-width helper shared by the register demux.
package reg_demux_pkg;
  typedef enum logic [1:0] {IDLE, FWD, ERR} state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/reg_demux_addr_decode.sv
// reg_demux_addr_decode: address-to-port decode; lowest hitting index wins.
//   addr : request address
//   hit  : some port matches (addr & PortMask[i]) == PortBase[i]
//   idx  : lowest matching port index (0 when no hit)
module reg_demux_addr_decode import reg_demux_pkg::*; #(
  parameter int NoPorts = 4,
  parameter int AW = 32,
  parameter logic [NoPorts-1:0][AW-1:0] PortBase = '0,
  parameter logic [NoPorts-1:0][AW-1:0] PortMask = '0,
  localparam int IW = idx_w(NoPorts)
) (
  input  logic [AW-1:0] addr,
  output logic          hit,
  output logic [IW-1:0] idx
);
  // Scan downward so the lowest-index match is written last and wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NoPorts - 1; i >= 0; i--)
      if ((addr & PortMask[i]) == PortBase[i]) begin
        hit = 1'b1;
        idx = IW'(i);
      end
  end
endmodule

// File: rtl/reg_demux_timeout.sv
// reg_demux_timeout: 1:N register-bus demux with registered request, decode-miss and timeout error replies.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   in_req_*_i          : initiator request (addr, write, wdata, wstrb, valid)
//   in_rsp_*_o          : initiator response (rdata, error, ready)
//   out_req_*_o [N]     : per-target requests
//   out_rsp_*_i [N]     : per-target responses
//   decerr_o, timeout_o : one-cycle pulses in the error-reply cycle
//   busy_o              : transaction in progress
module reg_demux_timeout import reg_demux_pkg::*; #(
  parameter int NoPorts = 4,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter logic [NoPorts-1:0][AW-1:0] PortBase = '0,
  parameter logic [NoPorts-1:0][AW-1:0] PortMask = '0,
  parameter int TimeoutCycles = 256
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [AW-1:0]                   in_req_addr_i,
  input  logic                            in_req_write_i,
  input  logic [DW-1:0]                   in_req_wdata_i,
  input  logic [DW/8-1:0]                 in_req_wstrb_i,
  input  logic                            in_req_valid_i,
  output logic [DW-1:0]                   in_rsp_rdata_o,
  output logic                            in_rsp_error_o,
  output logic                            in_rsp_ready_o,
  output logic [NoPorts-1:0][AW-1:0]      out_req_addr_o,
  output logic [NoPorts-1:0]              out_req_write_o,
  output logic [NoPorts-1:0][DW-1:0]      out_req_wdata_o,
  output logic [NoPorts-1:0][DW/8-1:0]    out_req_wstrb_o,
  output logic [NoPorts-1:0]              out_req_valid_o,
  input  logic [NoPorts-1:0][DW-1:0]      out_rsp_rdata_i,
  input  logic [NoPorts-1:0]              out_rsp_error_i,
  input  logic [NoPorts-1:0]              out_rsp_ready_i,
  output logic                            decerr_o,
  output logic                            timeout_o,
  output logic                            busy_o
);
  localparam int IW = idx_w(NoPorts);
  localparam int CW = idx_w(TimeoutCycles + 1);
  localparam logic [CW-1:0] CntLast = CW'(TimeoutCycles - 1);
  state_e          state, state_n;
  logic [IW-1:0]   sel, idx;
  logic [CW-1:0]   cnt;
  logic            hit, tmo, sel_ready, tmo_hit;
  logic [AW-1:0]   p_addr;
  logic            p_write;
  logic [DW-1:0]   p_wdata;
  logic [DW/8-1:0] p_wstrb;
  reg_demux_addr_decode #(
    .NoPorts(NoPorts), .AW(AW), .PortBase(PortBase), .PortMask(PortMask)
  ) u_dec (
    .addr(in_req_addr_i), .hit(hit), .idx(idx)
  );
  assign sel_ready = out_rsp_ready_i[sel];
  assign tmo_hit   = (TimeoutCycles != 0) && (cnt == CntLast);
  assign busy_o    = state != IDLE;
  assign decerr_o  = (state == ERR) && !tmo;
  assign timeout_o = (state == ERR) && tmo;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      sel     <= '0;
      cnt     <= '0;
      tmo     <= 1'b0;
      p_addr  <= '0;
      p_write <= 1'b0;
      p_wdata <= '0;
      p_wstrb <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_req_valid_i && hit) begin
        sel     <= idx;
        cnt     <= '0;
        p_addr  <= in_req_addr_i;
        p_write <= in_req_write_i;
        p_wdata <= in_req_wdata_i;
        p_wstrb <= in_req_wstrb_i;
      end else if (state == FWD && !sel_ready && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
      // Remember why we are entering ERR: from FWD means timeout, from IDLE means decode miss.
      if (state_n == ERR) tmo <= (state == FWD);
    end
  end
  // A target ready in the same cycle as the timeout threshold still completes the transfer.
  always_comb begin
    state_n = (state == IDLE) ? (in_req_valid_i ? (hit ? FWD : ERR) : IDLE) :
              (state == FWD)  ? (sel_ready ? IDLE : (tmo_hit ? ERR : FWD)) : IDLE;
    out_req_valid_o = '0;
    out_req_addr_o  = '0;
    out_req_write_o = '0;
    out_req_wdata_o = '0;
    out_req_wstrb_o = '0;
    in_rsp_ready_o  = (state == ERR) || ((state == FWD) && sel_ready);
    in_rsp_error_o  = (state == ERR) || ((state == FWD) && out_rsp_error_i[sel]);
    in_rsp_rdata_o  = (state == FWD) ? out_rsp_rdata_i[sel] : '0;
    if (state == FWD) begin
      out_req_valid_o[sel] = 1'b1;
      out_req_addr_o[sel]  = p_addr;
      out_req_write_o[sel] = p_write;
      out_req_wdata_o[sel] = p_wdata;
      out_req_wstrb_o[sel] = p_wstrb;
    end
  end
endmodule
